// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types for the traffic phase controller: controller states, the
// per-direction lamp bundle, and the direction-index width helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_PED,
    ST_FLASH
  } state_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  function automatic int unsigned dir_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Panel-side bundle: WireIn request bits in, lamp/status register bits out.
interface traffic_phase_ctrl_if #(
  parameter int unsigned NUM_DIRS = 2
);
  import traffic_pkg::*;

  localparam int unsigned DIR_W = dir_w(NUM_DIRS);

  logic                ped_req;
  logic                night_mode;
  logic [NUM_DIRS-1:0] lamp_r;
  logic [NUM_DIRS-1:0] lamp_y;
  logic [NUM_DIRS-1:0] lamp_g;
  logic                walk;
  logic                dont_walk;
  logic [DIR_W-1:0]    active_dir;
  logic                ped_pending;

  modport master (
    output ped_req, night_mode,
    input  lamp_r, lamp_y, lamp_g, walk, dont_walk, active_dir, ped_pending
  );

  modport slave (
    input  ped_req, night_mode,
    output lamp_r, lamp_y, lamp_g, walk, dont_walk, active_dir, ped_pending
  );

endinterface

// File: rtl/traffic_phase_ctrl_timer.sv
// Phase counter: runs 0..len-1, flags done on the last count, cleared synchronously.
module phase_timer #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else          count <= count + 1'b1;
  end

  assign done = (count == len - 1'b1);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase sequencer with latched pedestrian phase and
// flashing-red night mode; lamps are Moore-decoded from registered state.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS = 2,
  parameter int unsigned CNT_W    = 28,
  parameter int unsigned T_GREEN  = 100_000_000,
  parameter int unsigned T_YELLOW = 50_000_000,
  parameter int unsigned T_ALLRED = 0,
  parameter int unsigned T_PED    = 100_000_000,
  parameter int unsigned T_FLASH  = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int unsigned DIR_W = dir_w(NUM_DIRS);
  localparam logic [CNT_W-1:0] LEN_G = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] LEN_Y = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] LEN_A = CNT_W'((T_ALLRED == 0) ? 1 : T_ALLRED);
  localparam logic [CNT_W-1:0] LEN_P = CNT_W'(T_PED);
  localparam logic [CNT_W-1:0] LEN_F = CNT_W'(T_FLASH);

  state_t           state, state_nx;
  logic [DIR_W-1:0] dir, dir_nx, dir_inc;
  logic             pend, pend_nx;
  logic             ped_prev, ped_edge;
  logic             flash_ph, flash_nx;
  logic             hold, hold_nx;
  logic             clear_exit;
  logic [CNT_W-1:0] len;
  logic             done;
  logic             clr;

  always_comb begin
    case (state)
      ST_GREEN:  len = LEN_G;
      ST_YELLOW: len = LEN_Y;
      ST_ALLRED: len = LEN_A;
      ST_PED:    len = LEN_P;
      default:   len = LEN_F;
    endcase
  end

  // Cleared on every state change, and on each flash half-period wrap.
  assign clr = (state_nx != state) || done;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .len   (len),
    .done  (done)
  );

  assign ped_edge = bus.ped_req & ~ped_prev;
  assign dir_inc  = (dir == DIR_W'(NUM_DIRS - 1)) ? '0 : dir + 1'b1;

  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    hold_nx    = hold;
    clear_exit = 1'b0;
    case (state)
      ST_GREEN:  if (bus.night_mode || done) state_nx = ST_YELLOW;
      ST_YELLOW: if (done) begin
                   if (T_ALLRED != 0) state_nx = ST_ALLRED;
                   else               clear_exit = 1'b1;
                 end
      ST_ALLRED: if (done) clear_exit = 1'b1;
      ST_PED:    if (done) begin
                   state_nx = ST_GREEN;
                   dir_nx   = dir_inc;
                 end
      ST_FLASH:  if (!bus.night_mode) begin
                   dir_nx = '0;
                   if (T_ALLRED != 0) begin
                     state_nx = ST_ALLRED;
                     hold_nx  = 1'b1;
                   end else begin
                     state_nx = ST_GREEN;
                   end
                 end
      default:   state_nx = ST_GREEN;
    endcase
    // hold keeps direction 0 through the clearance that follows night mode.
    if (clear_exit) begin
      hold_nx = 1'b0;
      if (bus.night_mode) state_nx = ST_FLASH;
      else if (pend)      state_nx = ST_PED;
      else begin
        state_nx = ST_GREEN;
        dir_nx   = hold ? dir : dir_inc;
      end
    end
  end

  always_comb begin
    flash_nx = 1'b1;
    if (state == ST_FLASH && state_nx == ST_FLASH) flash_nx = flash_ph ^ done;
  end

  assign pend_nx = (state_nx == ST_PED && state != ST_PED) ? 1'b0 : (pend | ped_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_GREEN;
      dir      <= '0;
      pend     <= 1'b0;
      ped_prev <= 1'b1;
      flash_ph <= 1'b1;
      hold     <= 1'b0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      pend     <= pend_nx;
      ped_prev <= bus.ped_req;
      flash_ph <= flash_nx;
      hold     <= hold_nx;
    end
  end

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
    lamp_t lamp;
    logic  own;
    assign own    = (dir == DIR_W'(i));
    assign lamp.g = own && (state == ST_GREEN);
    assign lamp.y = own && (state == ST_YELLOW);
    assign lamp.r = (state == ST_FLASH) ? flash_ph
                                        : !(own && (state == ST_GREEN || state == ST_YELLOW));
    assign bus.lamp_r[i] = lamp.r;
    assign bus.lamp_y[i] = lamp.y;
    assign bus.lamp_g[i] = lamp.g;
  end

  assign bus.walk        = (state == ST_PED);
  assign bus.dont_walk   = (state != ST_PED);
  assign bus.active_dir  = dir;
  assign bus.ped_pending = pend;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised successor to the board's two-road traffic-light controller. It sequences NUM_DIRS approach directions round-robin through green, yellow and all-red clearance, and serves a latched pedestrian walk phase. It adds a night mode with flashing red. It sits behind the FrontPanel WireIn: `ped_req` and `night_mode` are WireIn bits already in the `clk` domain, and the lamp outputs drive the LED register (inverted at top level).

## Interface
- NUM_DIRS, 2: number of directions, legal range 2..8.
- CNT_W, 28: phase counter width; must hold max(T_*) − 1.
- T_GREEN, 100_000_000: green duration in cycles, ≥1.
- T_YELLOW, 50_000_000: yellow duration in cycles, ≥1.
- T_ALLRED, 0: all-red clearance in cycles; 0 means the state is skipped.
- T_PED, 100_000_000: walk phase duration in cycles, ≥1.
- T_FLASH, 50_000_000: flash half-period in cycles, ≥1.
- clk  in  1  system clock (IBUFGDS output).
- rst_n  in  1  asynchronous, active-low reset.
- ped_req  in  1  pedestrian request level; a rising edge registers a request.
- night_mode  in  1  level; 1 requests flashing-red mode.
- lamp_r / lamp_y / lamp_g  out  NUM_DIRS each  per-direction lamps, active high.
- walk, dont_walk  out  1 each  pedestrian lamps.
- active_dir  out  $clog2(NUM_DIRS)  direction currently owning green/yellow.
- ped_pending  out  1  a latched request is awaiting service.

## Operation
- States: GREEN, YELLOW, ALLRED, PED, FLASH. Lamps are Moore-decoded from the state, active_dir and flash_ph registers.
- GREEN: lamp_g[active_dir]=1 and the other directions are red. YELLOW: lamp_y[active_dir]=1 and the others are red. ALLRED, PED: all red. FLASH: lamp_r = {NUM_DIRS{flash_ph}}, lamp_y = lamp_g = 0.
- walk=1 only in PED. dont_walk = ~walk.
- A state lasts exactly its T cycles. The counter runs 0..T−1, and the transition fires on the edge where counter==T−1; the counter is zeroed on every state change.
- GREEN → YELLOW at T_GREEN. GREEN → YELLOW immediately (next edge) if night_mode=1, so green is cut short but yellow is never skipped.
- YELLOW → ALLRED at T_YELLOW, or takes the ALLRED exit directly if T_ALLRED=0.
- ALLRED exit priority:
  1. night_mode → FLASH.
  2. ped_pending → PED.
  3. Otherwise → GREEN with active_dir+1, wrapping NUM_DIRS−1→0.
- PED → GREEN with active_dir+1 at T_PED.
- FLASH: flash_ph toggles every T_FLASH cycles and starts at 1 on entry. When night_mode=0, the next edge goes to ALLRED (or straight to GREEN if T_ALLRED=0), with active_dir forced to 0.
- Ped edge detect: ped_prev ← ped_req. An edge is ped_req & ~ped_prev. ped_prev resets to 1, so a level held high through reset is ignored.
- An edge sets ped_pending. Entering PED clears it. An edge on the same cycle PED is entered is absorbed (it is served by that PED). An edge during PED or FLASH sets ped_pending for the next cycle.

## Timing
- Reset values: state=GREEN, active_dir=0, counter=0, ped_pending=0, flash_ph=1.
  - Outputs: lamp_g=1 on bit 0 only, lamp_r=~1 on bits above 0, lamp_y=0, walk=0, dont_walk=1.
- An async assert mid-phase returns to the reset state immediately. Operation restarts on the first clk edge after deassertion.
- Ped latency: edge at cycle n → ped_pending=1 at n+1.
- night_mode sampled at n in GREEN → YELLOW lamps at n+1.
- Full non-ped cycle per direction: T_GREEN+T_YELLOW+T_ALLRED.

## Structure
- Package `traffic_pkg`: the state enum, the lamp bundle typedef, and the DIR_W = $clog2(NUM_DIRS) helper.
- Sub-module `phase_timer`: CNT_W counter with synchronous clear, a `len` input and a `done` output (counter==len−1). One instance, whose len is muxed by state.

## Test plan
Parameters for all scenarios: NUM_DIRS=3, T_GREEN=10, T_YELLOW=4, T_ALLRED=2, T_PED=6, T_FLASH=3.
- Reset release, no inputs → G0 ×10 cycles, Y0 ×4, all-red ×2, G1, …; after G2 the sequence wraps to G0. Each period is 16 cycles.
- ped_req held high through reset → no PED ever; ped_pending stays 0.
- ped_req pulse during G1 → ped_pending=1 the next cycle; after Y1 and all-red, walk=1 for 6 cycles; then G2 and ped_pending=0.
- Two pulses in one G0 → a single PED. A pulse on the PED entry edge → no second PED.
- night_mode=1 mid-G0 → Y0 on the next cycle for 4, all-red 2, then FLASH with lamp_r=3'b111 for 3 cycles, then 3'b000 for 3. night_mode=0 → all-red 2, then G0.
- rst_n low in the middle of PED → outputs return to reset values immediately; ped_pending=0.
